// File: rtl/pwm_update_controller.sv
// PWM output sequencer: shadows the SPI config and applies changes only at period boundaries.
// Optional PWM_PERIOD_STROBE_EN adds period_strobe and update_applied pulse outputs.
module pwm_update_controller #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned DIV_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] pwm_out,
    output logic        active,
    output logic        update_pending
`ifdef PWM_PERIOD_STROBE_EN
    ,
    output logic        period_strobe,
    output logic        update_applied
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

    localparam logic [DIV_W-1:0] PRESC_MAX = DIV_W'(CLK_DIV - 1);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      sh_en_out;
    logic [15:0]      sh_en_pwm;
    logic [7:0]       sh_duty;
    logic [DIV_W-1:0] presc;
    logic [7:0]       cnt;
    logic [39:0]      live_cfg;
    logic [39:0]      shadow_cfg;
    logic             live_on;
    logic             diff;
    logic             running;
    logic             tick;
    logic             period_end;
    logic             level;
    logic             load;
    logic [15:0]      pwm_nxt;

    assign live_cfg   = {en_reg_out_15_8, en_reg_out_7_0, en_reg_pwm_15_8, en_reg_pwm_7_0, pwm_duty_cycle};
    assign shadow_cfg = {sh_en_out, sh_en_pwm, sh_duty};
    assign live_on    = |{en_reg_out_15_8, en_reg_out_7_0};
    assign diff       = live_cfg != shadow_cfg;
    assign running    = state != IDLE;
    assign tick       = running && (presc == PRESC_MAX);
    assign period_end = tick && (cnt == 8'hFF);

    // Full-scale duty must stay high through cnt==255, which cnt < sd cannot express.
    assign level   = (sh_duty == 8'hFF) || (cnt < sh_duty);
    assign pwm_nxt = sh_en_out & (~sh_en_pwm | {16{level}});

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        if (!live_on) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
                RUN: begin
                    if (diff) state_nxt = PENDING;
                end
                PENDING: begin
                    if (!diff) begin
                        state_nxt = RUN;
                    end else if (period_end) begin
                        state_nxt = RUN;
                        load      = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            active         <= 1'b0;
            update_pending <= 1'b0;
            pwm_out        <= '0;
            sh_en_out      <= '0;
            sh_en_pwm      <= '0;
            sh_duty        <= '0;
            presc          <= '0;
            cnt            <= '0;
`ifdef PWM_PERIOD_STROBE_EN
            period_strobe  <= 1'b0;
            update_applied <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            active         <= state_nxt != IDLE;
            update_pending <= state_nxt == PENDING;
            pwm_out        <= pwm_nxt;

            if (load) begin
                sh_en_out <= {en_reg_out_15_8, en_reg_out_7_0};
                sh_en_pwm <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
                sh_duty   <= pwm_duty_cycle;
            end else if (!live_on) begin
                sh_en_out <= '0;
            end

            // Leaving or entering IDLE restarts the period so the first one is never truncated.
            if (!live_on || state == IDLE) begin
                presc <= '0;
                cnt   <= '0;
            end else begin
                presc <= tick ? '0 : presc + DIV_W'(1);
                if (tick) cnt <= cnt + 8'd1;
            end
`ifdef PWM_PERIOD_STROBE_EN
            period_strobe  <= period_end;
            update_applied <= load;
`endif
        end
    end

endmodule
